// File: rtl/chebyshev_horner_engine_pkg.sv
// Shared definitions for the Horner polynomial engine: FSM encoding, default
// formats and the sign-extend / round-half-up / saturate helpers.
package chebyshev_pkg;

    localparam int WL_DEF       = 16;
    localparam int CL_DEF       = 16;
    localparam int DEGREE_DEF   = 4;
    localparam int WIDENING_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int acc_width(input int cl, input int widening);
        return cl + widening;
    endfunction

    function automatic int addr_width(input int degree);
        return (degree < 2) ? 1 : $clog2(degree + 1);
    endfunction

    // Interpret the low w bits of v as a two's-complement number.
    function automatic logic signed [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int unsigned sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/chebyshev_horner_engine_if.sv
// Control, coefficient-load and result signals of the Horner engine.
interface chebyshev_horner_engine_if #(
    parameter int WL = 16,
    parameter int CL = 16,
    parameter int AW = 19,
    parameter int AB = 3
);
    logic          coeff_we;
    logic [AB-1:0] coeff_addr;
    logic [CL-1:0] coeff_data;
    logic          start;
    logic [WL-1:0] data_in;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] data_out;
    logic          ovf;

    modport master (
        output coeff_we, coeff_addr, coeff_data, start, data_in, out_ready,
        input  busy, out_valid, data_out, ovf
    );

    modport slave (
        input  coeff_we, coeff_addr, coeff_data, start, data_in, out_ready,
        output busy, out_valid, data_out, ovf
    );
endinterface

// File: rtl/chebyshev_horner_engine_mac.sv
// Combinational datapath: y*x rounded half-up and saturated, prod+c saturated.
module cheb_mac_round_sat
    import chebyshev_pkg::*;
#(
    parameter int WL = 16,
    parameter int CL = 16,
    parameter int AW = 19
) (
    input  logic [AW-1:0] y_i,
    input  logic [WL-1:0] x_i,
    input  logic [AW-1:0] prod_i,
    input  logic [CL-1:0] coef_i,
    output logic [AW-1:0] prod_o,
    output logic          mul_ovf_o,
    output logic [AW-1:0] sum_o,
    output logic          add_ovf_o
);
    logic signed [63:0] full_s;
    logic signed [63:0] rnd_s;
    logic signed [63:0] prod_sat_s;
    logic signed [63:0] sum_s;
    logic signed [63:0] sum_sat_s;

    // Product keeps WL-2 extra fraction bits, dropped by the rounding shift.
    always_comb begin
        full_s     = sext(64'(y_i), AW) * sext(64'(x_i), WL);
        rnd_s      = rnd_shr(full_s, WL - 2);
        prod_sat_s = sat(rnd_s, AW);
        sum_s      = sext(64'(prod_i), AW) + sext(64'(coef_i), CL);
        sum_sat_s  = sat(sum_s, AW);
    end

    assign prod_o    = AW'(prod_sat_s);
    assign mul_ovf_o = (prod_sat_s != rnd_s);
    assign sum_o     = AW'(sum_sat_s);
    assign add_ovf_o = (sum_sat_s != sum_s);
endmodule

// File: rtl/chebyshev_horner_engine.sv
// Horner-recurrence polynomial evaluator with loadable coefficient bank,
// start/done handshake and sticky saturation flag.
module chebyshev_horner_engine
    import chebyshev_pkg::*;
#(
    parameter int WL       = WL_DEF,
    parameter int CL       = CL_DEF,
    parameter int DEGREE   = DEGREE_DEF,
    parameter int WIDENING = WIDENING_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    chebyshev_horner_engine_if.slave  bus
);
    localparam int AW = acc_width(CL, WIDENING);
    localparam int AB = addr_width(DEGREE);

    state_e        state_q, state_d;
    logic [WL-1:0] x_q;
    logic [AW-1:0] y_q;
    logic [AW-1:0] prod_q;
    logic [AB-1:0] k_q;
    logic [CL-1:0] coef_q [DEGREE+1];
    logic [AW-1:0] data_out_q;
    logic          out_valid_q;
    logic          ovf_q;
    logic          busy_s;
    logic [AW-1:0] prod_s;
    logic [AW-1:0] sum_s;
    logic          mul_ovf_s;
    logic          add_ovf_s;

    cheb_mac_round_sat #(.WL(WL), .CL(CL), .AW(AW)) u_mac (
        .y_i       (y_q),
        .x_i       (x_q),
        .prod_i    (prod_q),
        .coef_i    (coef_q[k_q]),
        .prod_o    (prod_s),
        .mul_ovf_o (mul_ovf_s),
        .sum_o     (sum_s),
        .add_ovf_o (add_ovf_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_MUL; else state_d = ST_IDLE;
            ST_MUL:  state_d = ST_ADD;
            ST_ADD:  if (k_q == AB'(0)) state_d = ST_DONE; else state_d = ST_MUL;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE; else state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_s = (state_q != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q         <= {WL{1'b0}};
            y_q         <= {AW{1'b0}};
            prod_q      <= {AW{1'b0}};
            k_q         <= {AB{1'b0}};
            data_out_q  <= {AW{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i <= DEGREE; i++) coef_q[i] <= {CL{1'b0}};
        end else begin
            out_valid_q <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (bus.coeff_we && (int'(bus.coeff_addr) <= DEGREE)) begin
                        coef_q[bus.coeff_addr] <= bus.coeff_data;
                    end
                    if (bus.start) begin
                        x_q   <= bus.data_in;
                        y_q   <= AW'(sext(64'(coef_q[DEGREE]), CL));
                        k_q   <= AB'(DEGREE - 1);
                        ovf_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    prod_q <= prod_s;
                    if (mul_ovf_s) ovf_q <= 1'b1;
                end
                ST_ADD: begin
                    y_q <= sum_s;
                    if (add_ovf_s) ovf_q <= 1'b1;
                    // The final sum is latched as the result while entering DONE.
                    if (k_q == AB'(0)) begin
                        data_out_q <= sum_s;
                    end else begin
                        k_q <= k_q - AB'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = busy_s;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chebyshev_horner_engine.sv
// Directed bench for chebyshev_horner_engine with hand-computed results (Q5.14 accumulator).
module tb_chebyshev_horner_engine;
    localparam int WL = 16;
    localparam int CL = 16;
    localparam int DEGREE = 4;
    localparam int WIDENING = 3;
    localparam int AW = 19;
    localparam int AB = 3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   lat;

    chebyshev_horner_engine_if #(.WL(WL), .CL(CL), .AW(AW), .AB(AB)) bus ();

    chebyshev_horner_engine #(.WL(WL), .CL(CL), .DEGREE(DEGREE), .WIDENING(WIDENING)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = AB'(a);
        bus.coeff_data = d;
        tick();
        bus.coeff_we   = 1'b0;
    endtask

    task automatic clear_coefs();
        for (int i = 0; i <= DEGREE; i++) wr(i, 16'h0000);
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    // Start an evaluation; n is the number of edges from acceptance to out_valid.
    task automatic eval(input logic [15:0] x, output int n);
        bus.data_in = x;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        wait_valid(n);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("accept_valid_low", 32'(bus.out_valid), 32'h0);
        chk("accept_idle", 32'(bus.busy), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.coeff_we = 1'b0; bus.coeff_addr = '0; bus.coeff_data = '0;
        bus.start = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);

        // constant polynomial c0=0.5
        wr(0, 16'h2000);
        eval(16'h4000, lat);
        chk("c0_latency", 32'(lat), 32'd9);
        chk("c0_data", 32'(bus.data_out), 32'h02000);
        chk("c0_ovf", 32'(bus.ovf), 32'h0);
        accept();

        // x^4 at x=0.5
        clear_coefs();
        wr(4, 16'h4000);
        eval(16'h2000, lat);
        chk("x4_latency", 32'(lat), 32'd9);
        chk("x4_data", 32'(bus.data_out), 32'h00400);
        chk("x4_ovf", 32'(bus.ovf), 32'h0);
        accept();

        // rounding ties: +1 lsb * 0.5 rounds up, -1 lsb * 0.5 rounds to 0
        clear_coefs();
        wr(1, 16'h0001);
        eval(16'h2000, lat);
        chk("tie_pos", 32'(bus.data_out), 32'h00001);
        accept();
        wr(1, 16'hFFFF);
        eval(16'h2000, lat);
        chk("tie_neg", 32'(bus.data_out), 32'h00000);
        accept();

        // saturation
        for (int i = 0; i <= DEGREE; i++) wr(i, 16'h7FFF);
        eval(16'h7FFF, lat);
        chk("sat_data", 32'(bus.data_out), 32'h3FFFF);
        chk("sat_ovf", 32'(bus.ovf), 32'h1);
        accept();
        chk("sat_ovf_sticky", 32'(bus.ovf), 32'h1);
        clear_coefs();
        wr(0, 16'h2000);
        wr(7, 16'h7FFF);
        bus.data_in = 16'h4000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ovf_cleared_on_start", 32'(bus.ovf), 32'h0);
        wait_valid(lat);
        chk("post_sat_data", 32'(bus.data_out), 32'h02000);
        chk("post_sat_ovf", 32'(bus.ovf), 32'h0);
        accept();

        // handshake: writes and starts while busy are dropped, DONE holds
        bus.data_in = 16'h4000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.coeff_we = 1'b1; bus.coeff_addr = 3'd0; bus.coeff_data = 16'h1234;
        bus.start = 1'b1; bus.data_in = 16'h7FFF;
        tick();
        bus.coeff_we = 1'b0; bus.start = 1'b0;
        wait_valid(lat);
        chk("hs_valid", 32'(bus.out_valid), 32'h1);
        chk("hs_data", 32'(bus.data_out), 32'h02000);
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(bus.out_valid), 32'h1);
            chk("hold_data", 32'(bus.data_out), 32'h02000);
        end
        bus.start = 1'b0;
        accept();
        eval(16'h4000, lat);
        chk("readback_c0", 32'(bus.data_out), 32'h02000);
        accept();

        // reset during MUL of the second iteration
        wr(4, 16'h4000);
        bus.data_in = 16'h2000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_valid", 32'(bus.out_valid), 32'h0);
        end
        eval(16'h4000, lat);
        chk("abort_latency", 32'(lat), 32'd9);
        chk("abort_zero_coefs", 32'(bus.data_out), 32'h00000);
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
